mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store unit directly upstream of the word-wide data memory: accepts MIPS
//  LB/LBU/LH/LHU/LW/SB/SH/SW requests from EX and drives the memory's word port.
//  Extracts and extends sub-word loads, does read-modify-write for SB/SH, checks alignment.
//  Memory read is combinational; memory write happens at posedge clk when mem_wr=1.
// PARAMETERS
//  ADDR_W      12  byte-address width; word index = addr[ADDR_W-1:2]
//  BIG_ENDIAN  0   0: byte lane = addr[1:0]; 1: byte lane = 3-addr[1:0]
// PORTS
//  clk         in   1       clock, all state updates at posedge
//  rst         in   1       synchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit can accept a request
//  req_wr      in   1       1=store, 0=load (MIPS opcode[3])
//  req_op      in   3       MIPS opcode[2:0]: [1:0] 00=byte,01=half,11=word,10=illegal; [2]=unsigned load
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data, right-aligned
//  resp_valid  out  1       response present
//  resp_ready  in   1       consumer takes response
//  resp_data   out  32      extended load data; 0 for stores
//  resp_err    out  1       misaligned or illegal request
//  mem_addr    out  ADDR_W  to data memory address, low 2 bits forced 00
//  mem_wdata   out  32      to data memory write data
//  mem_wr      out  1       to data memory write enable
//  mem_rdata   in   32      from data memory read data
// BEHAVIOUR
//  States: IDLE, ACCESS, WRITE, RESP. After reset: IDLE.
//  Reset values: req_ready=0 during rst cycle, else 1 in IDLE; resp_valid=0, resp_data=0,
//   resp_err=0, mem_wr=0, mem_addr=0, mem_wdata=0.
//  IDLE: req_ready=1; on req_valid: latch wr/op/addr/wdata.
//   Go to RESP with resp_err=1 if the request faults (see CONFIGURATION); else go to ACCESS.
//  ACCESS: mem_addr={addr[ADDR_W-1:2],2'b00}.
//   Load: resp_data <= extracted lane; sign-extend if op[2]=0, zero-extend if op[2]=1 -> RESP.
//   SW: mem_wr=1, mem_wdata=wdata -> RESP.
//   SB/SH: merge reg <= mem_rdata with the addressed lane(s) replaced by wdata[7:0]/[15:0] -> WRITE.
//  WRITE: mem_wr=1, mem_wdata=merge reg, same mem_addr -> RESP.
//  RESP: resp_valid=1, outputs held stable until resp_ready=1; then IDLE. req_ready=0 outside IDLE.
//  Latency accept->resp_valid: loads/SW 2 cycles, SB/SH 3 cycles, faults 1 cycle.
//  Halfword lane: addr[1]; with BIG_ENDIAN=1, byte lane=3-addr[1:0] and halfword lane=~addr[1].
//  mem_wr is exactly one cycle per store, never asserted for loads or faults.
//  mem_wr is gated combinationally with ~rst: reset mid-ACCESS/WRITE suppresses the write.
//  Next request is accepted only in IDLE. There is no overlap, so the memory sees one access at a time.
// CONFIGURATION
//  MAU_ALIGN_TRAP_EN defined: a request faults if it is a halfword with addr[0]!=0,
//   a word with addr[1:0]!=0, or size=10. A faulting request makes no memory access,
//   returns resp_data=0 and resp_err=1.
//  Not defined: resp_err is tied 0. Half/word low address bits are ignored and the lane
//   is forced aligned. Size 10 is treated as a word.
// TESTING
//  Preload word[4] (byte 0x010) = 0x8899AABB, BIG_ENDIAN=0.
//  LB 0x011 -> resp_data=0xFFFFFFAA; LBU 0x013 -> 0x00000088.
//   resp_valid 2 cycles after accept, mem_wr never high.
//  LH 0x012 -> 0xFFFF8899; LHU 0x010 -> 0x0000AABB; LW 0x010 -> 0x8899AABB.
//  SB 0x012 wdata=0x00000055 -> word[4]=0x8855AABB; mem_wr high exactly 1 cycle;
//   resp_valid 3 cycles after accept. Then SH 0x010 wdata=0x1234 -> word[4]=0x88551234.
//  LW 0x016 with MAU_ALIGN_TRAP_EN -> resp_err=1, resp_data=0, no mem_wr, 1-cycle latency.
//   Without the macro -> resp_err=0, resp_data=word[5].
//  Hold resp_ready=0 for 5 cycles after LW -> resp_valid/resp_data stable, req_ready=0,
//   new req_valid ignored. Release -> IDLE next cycle.
//  Assert rst in the WRITE cycle of SB 0x010 -> word[4] unchanged; next cycle all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between EX and the load/store unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store unit in front of a word-wide data memory: sub-word extract/extend and SB/SH read-modify-write.
// Optional feature macro: MAU_ALIGN_TRAP_EN (misaligned/illegal-size requests fault instead of being forced aligned).
module mem_access_unit #(
    parameter int ADDR_W     = 12,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

    state_t            state_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [31:0]       resp_data_r;
    logic              resp_err_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              wr_r;
    logic [2:0]        op_r;
    logic [1:0]        lane_r;
    logic [15:0]       wdata_r;
    logic              fault_s;

    // Select the addressed byte/halfword of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] op,
                                                 input logic [1:0] a);
        logic [1:0]  bl;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        bl = BIG_ENDIAN ? (2'd3 - a) : a;
        case (bl)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = (a[1] ^ BIG_ENDIAN) ? rdata[31:16] : rdata[15:0];
        case (op[1:0])
            2'b00:   res = op[2] ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = op[2] ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/halfword lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] rdata, input logic [15:0] wd,
                                                input logic [1:0] size, input logic [1:0] a);
        logic [1:0]  bl;
        logic [31:0] res;
        bl  = BIG_ENDIAN ? (2'd3 - a) : a;
        res = rdata;
        case (size)
            2'b00: begin
                case (bl)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (a[1] ^ BIG_ENDIAN) res[31:16] = wd;
                else                   res[15:0]  = wd;
            end
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Fault decode for the incoming request.
    always_comb begin
`ifdef MAU_ALIGN_TRAP_EN
        fault_s = ((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) ||
                  ((bus.req_op[1:0] == 2'b11) && (bus.req_addr[1:0] != 2'b00)) ||
                  (bus.req_op[1:0] == 2'b10);
`else
        fault_s = 1'b0;
`endif
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
            wr_r         <= 1'b0;
            op_r         <= 3'b000;
            lane_r       <= 2'b00;
            wdata_r      <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_r        <= bus.req_wr;
                        op_r        <= bus.req_op;
                        lane_r      <= bus.req_addr[1:0];
                        wdata_r     <= bus.req_wdata[15:0];
                        req_ready_r <= 1'b0;
                        resp_data_r <= 32'h0000_0000;
                        if (fault_s) begin
                            resp_err_r   <= 1'b1;
                            resp_valid_r <= 1'b1;
                            state_r      <= RESP;
                        end else begin
                            mem_addr_r <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            // Full-word stores need no read, so the write fires in ACCESS.
                            if (bus.req_wr && bus.req_op[1]) begin
                                mem_wr_r    <= 1'b1;
                                mem_wdata_r <= bus.req_wdata;
                            end else begin
                                mem_wr_r <= 1'b0;
                            end
                            state_r <= ACCESS;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!wr_r) begin
                        mem_wr_r     <= 1'b0;
                        resp_data_r  <= load_extract(mem_rdata, op_r, lane_r);
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else if (op_r[1]) begin
                        mem_wr_r     <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        mem_wdata_r <= store_merge(mem_rdata, wdata_r, op_r[1:0], lane_r);
                        mem_wr_r    <= 1'b1;
                        state_r     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_wr_r     <= 1'b0;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_data_r  <= 32'h0000_0000;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Reset gating keeps a write from landing in the cycle reset is asserted.
    assign mem_wr         = mem_wr_r & ~rst;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign bus.req_ready  = req_ready_r & ~rst;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (little-endian, ADDR_W=12).
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [2:0]  ld_op   [0:4];
    logic [11:0] ld_addr [0:4];
    logic [31:0] ld_exp  [0:4];

    mem_access_unit_if #(.ADDR_W(12)) bus ();

    mem_access_unit #(.ADDR_W(12), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic do_req(input logic wr, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] wdata, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_op = op;
        bus.req_addr = addr; bus.req_wdata = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_resp();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.req_wr = 1'b0; bus.req_op = 3'b000; bus.req_addr = 12'h000; bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b0) begin $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); errors++; end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin $display("FAIL idle_req_ready got=%b exp=1", bus.req_ready); errors++; end
        checks++; if (bus.resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); errors++; end
        checks++; if (bus.resp_data !== 32'h0) begin $display("FAIL rst_resp_data got=%h exp=0", bus.resp_data); errors++; end
        checks++; if (bus.resp_err !== 1'b0) begin $display("FAIL rst_resp_err got=%b exp=0", bus.resp_err); errors++; end
        checks++; if (mem_wr !== 1'b0 || mem_addr !== 12'h000 || mem_wdata !== 32'h0) begin
            $display("FAIL rst_mem_port got wr=%b addr=%h wdata=%h exp 0/0/0", mem_wr, mem_addr, mem_wdata); errors++; end
    endtask

    task automatic test_loads();
        int lat;
        int c0;
        ld_op[0] = 3'b000; ld_addr[0] = 12'h011; ld_exp[0] = 32'hFFFF_FFAA;
        ld_op[1] = 3'b100; ld_addr[1] = 12'h013; ld_exp[1] = 32'h0000_0088;
        ld_op[2] = 3'b001; ld_addr[2] = 12'h012; ld_exp[2] = 32'hFFFF_8899;
        ld_op[3] = 3'b101; ld_addr[3] = 12'h010; ld_exp[3] = 32'h0000_AABB;
        ld_op[4] = 3'b011; ld_addr[4] = 12'h010; ld_exp[4] = 32'h8899_AABB;
        for (int i = 0; i < 5; i++) begin
            c0 = wr_cnt;
            do_req(1'b0, ld_op[i], ld_addr[i], 32'h0, lat);
            checks++; if (lat !== 2) begin $display("FAIL load%0d_latency got=%0d exp=2", i, lat); errors++; end
            checks++; if (bus.resp_data !== ld_exp[i]) begin $display("FAIL load%0d_data got=%h exp=%h", i, bus.resp_data, ld_exp[i]); errors++; end
            checks++; if (bus.resp_err !== 1'b0) begin $display("FAIL load%0d_err got=%b exp=0", i, bus.resp_err); errors++; end
            checks++; if (wr_cnt !== c0) begin $display("FAIL load%0d_no_write got=%0d exp=%0d", i, wr_cnt, c0); errors++; end
            release_resp();
        end
    endtask

    task automatic test_stores();
        int lat;
        int c0;
        c0 = wr_cnt;
        do_req(1'b1, 3'b000, 12'h012, 32'h0000_0055, lat);
        checks++; if (lat !== 3) begin $display("FAIL sb_latency got=%0d exp=3", lat); errors++; end
        checks++; if (mem[4] !== 32'h8855_AABB) begin $display("FAIL sb_word got=%h exp=8855aabb", mem[4]); errors++; end
        checks++; if (wr_cnt !== c0 + 1) begin $display("FAIL sb_wr_cycles got=%0d exp=%0d", wr_cnt - c0, 1); errors++; end
        checks++; if (bus.resp_data !== 32'h0) begin $display("FAIL sb_resp_data got=%h exp=0", bus.resp_data); errors++; end
        release_resp();
        c0 = wr_cnt;
        do_req(1'b1, 3'b001, 12'h010, 32'h0000_1234, lat);
        checks++; if (lat !== 3) begin $display("FAIL sh_latency got=%0d exp=3", lat); errors++; end
        checks++; if (mem[4] !== 32'h8855_1234) begin $display("FAIL sh_word got=%h exp=88551234", mem[4]); errors++; end
        checks++; if (wr_cnt !== c0 + 1) begin $display("FAIL sh_wr_cycles got=%0d exp=%0d", wr_cnt - c0, 1); errors++; end
        release_resp();
        c0 = wr_cnt;
        do_req(1'b1, 3'b011, 12'h018, 32'hDEAD_BEEF, lat);
        checks++; if (lat !== 2) begin $display("FAIL sw_latency got=%0d exp=2", lat); errors++; end
        checks++; if (mem[6] !== 32'hDEAD_BEEF) begin $display("FAIL sw_word got=%h exp=deadbeef", mem[6]); errors++; end
        checks++; if (wr_cnt !== c0 + 1) begin $display("FAIL sw_wr_cycles got=%0d exp=%0d", wr_cnt - c0, 1); errors++; end
        release_resp();
    endtask

    task automatic test_misaligned();
        int lat;
        int c0;
        c0 = wr_cnt;
        do_req(1'b0, 3'b011, 12'h016, 32'h0, lat);
`ifdef MAU_ALIGN_TRAP_EN
        checks++; if (lat !== 1) begin $display("FAIL lw_mis_latency got=%0d exp=1", lat); errors++; end
        checks++; if (bus.resp_err !== 1'b1) begin $display("FAIL lw_mis_err got=%b exp=1", bus.resp_err); errors++; end
        checks++; if (bus.resp_data !== 32'h0) begin $display("FAIL lw_mis_data got=%h exp=0", bus.resp_data); errors++; end
`else
        checks++; if (lat !== 2) begin $display("FAIL lw_mis_latency got=%0d exp=2", lat); errors++; end
        checks++; if (bus.resp_err !== 1'b0) begin $display("FAIL lw_mis_err got=%b exp=0", bus.resp_err); errors++; end
        checks++; if (bus.resp_data !== 32'hCAFE_F00D) begin $display("FAIL lw_mis_data got=%h exp=cafef00d", bus.resp_data); errors++; end
`endif
        release_resp();
        do_req(1'b0, 3'b010, 12'h010, 32'h0, lat);
`ifdef MAU_ALIGN_TRAP_EN
        checks++; if (bus.resp_err !== 1'b1 || bus.resp_data !== 32'h0) begin
            $display("FAIL illegal_size got err=%b data=%h exp err=1 data=0", bus.resp_err, bus.resp_data); errors++; end
`else
        checks++; if (bus.resp_err !== 1'b0 || bus.resp_data !== 32'h8855_1234) begin
            $display("FAIL illegal_size got err=%b data=%h exp err=0 data=88551234", bus.resp_err, bus.resp_data); errors++; end
`endif
        checks++; if (wr_cnt !== c0) begin $display("FAIL fault_no_write got=%0d exp=%0d", wr_cnt, c0); errors++; end
        release_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        int c0;
        c0 = wr_cnt;
        do_req(1'b0, 3'b011, 12'h010, 32'h0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_op = 3'b011;
            bus.req_addr = 12'h018; bus.req_wdata = 32'h0000_0000;
            @(posedge clk);
            #1;
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h8855_1234) begin
                $display("FAIL hold%0d got valid=%b data=%h exp valid=1 data=88551234", i, bus.resp_valid, bus.resp_data); errors++; end
            checks++; if (bus.req_ready !== 1'b0) begin $display("FAIL hold%0d_req_ready got=%b exp=0", i, bus.req_ready); errors++; end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            $display("FAIL release_idle got ready=%b valid=%b exp ready=1 valid=0", bus.req_ready, bus.resp_valid); errors++; end
        checks++; if (mem[6] !== 32'hDEAD_BEEF || wr_cnt !== c0) begin
            $display("FAIL ignored_req got word6=%h writes=%0d exp deadbeef/0", mem[6], wr_cnt - c0); errors++; end
    endtask

    task automatic test_reset_in_write();
        int c0;
        c0 = wr_cnt;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_op = 3'b000;
        bus.req_addr = 12'h010; bus.req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (mem_wr !== 1'b1) begin $display("FAIL write_cycle_wr got=%b exp=1", mem_wr); errors++; end
        rst = 1'b1;
        #1;
        checks++; if (mem_wr !== 1'b0) begin $display("FAIL rst_gates_wr got=%b exp=0", mem_wr); errors++; end
        @(posedge clk);
        #1;
        checks++; if (mem[4] !== 32'h8855_1234 || wr_cnt !== c0) begin
            $display("FAIL rst_write_suppressed got word4=%h writes=%0d exp 88551234/0", mem[4], wr_cnt - c0); errors++; end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_err !== 1'b0) begin
            $display("FAIL rst_resp_outputs got v=%b d=%h e=%b exp 0/0/0", bus.resp_valid, bus.resp_data, bus.resp_err); errors++; end
        checks++; if (mem_wr !== 1'b0 || mem_addr !== 12'h000 || mem_wdata !== 32'h0 || bus.req_ready !== 1'b0) begin
            $display("FAIL rst_mem_outputs got wr=%b a=%h wd=%h rdy=%b exp 0/0/0/0", mem_wr, mem_addr, mem_wdata, bus.req_ready); errors++; end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin $display("FAIL post_rst_ready got=%b exp=1", bus.req_ready); errors++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899_AABB;
        mem[5] = 32'hCAFE_F00D;
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_backpressure();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
